// File: rtl/bin_bcd_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one conversion per WIDTH+1 cycles.
// Optional excess-3 output coding; sticky overflow when the value needs more than DIGITS digits.
module bin_bcd_dabble #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int EX3    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] adj;
    logic             ovf_sticky;

    // A digit of 5..9 becomes 8..12 so that the following shift carries into the next digit.
    function automatic logic [3:0] add3_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [BCD_W-1:0] out_code(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        if (EX3 != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3_adj(scratch[4*i +: 4]);
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg      <= bin;
                        scratch    <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CNT_W'(WIDTH);
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The top digit's MSB leaves the register here; remember it as overflow.
                    scratch    <= {adj[BCD_W-2:0], shreg[WIDTH-1]};
                    shreg      <= shreg << 1;
                    ovf_sticky <= ovf_sticky | adj[BCD_W-1];
                    cnt        <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd   <= out_code(scratch);
                    ovf   <= ovf_sticky;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
